// File: rtl/pl_mem_wb_pkg.sv
// rtl/pl_mem_wb_pkg.sv - shared definitions for the memory/writeback stage
package pl_defs;

    localparam int EXR_STORE      = 0;
    localparam int EXR_REG_WR     = 1;
    localparam int EXR_SAVE_COUT  = 2;
    localparam int EXR_INV_EX     = 3;
    localparam int EXR_LOAD       = 4;
    localparam int EXR_INV_FETCH  = 5;
    localparam int EXR_INV_DECODE = 6;
    localparam int EXR_DEST_RNS   = 7;
    localparam int EXR_OUTP       = 8;
    localparam int EXR_INP        = 9;

    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 16;
    localparam int PORT_W    = 8;
    localparam int RF_ADDR_W = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IO_WAIT = 2'd1,
        IO_WB   = 2'd2
    } io_state_t;

endpackage

// File: rtl/pl_mem_wb_if.sv
// rtl/pl_mem_wb_if.sv - data-memory and IO-port bus of the memory/writeback stage
interface pl_mem_wb_if;
    import pl_defs::*;

    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wr_data;
    logic [DATA_W-1:0] mem_rd_data;
    logic [PORT_W-1:0] io_port_id;
    logic [DATA_W-1:0] io_out_data;
    logic              io_wr_strobe;
    logic              io_rd_strobe;
    logic [DATA_W-1:0] io_in_data;
    logic              io_in_valid;

    modport master (
        output mem_wr_en, mem_addr, mem_wr_data,
        input  mem_rd_data,
        output io_port_id, io_out_data, io_wr_strobe, io_rd_strobe,
        input  io_in_data, io_in_valid
    );

    modport slave (
        input  mem_wr_en, mem_addr, mem_wr_data,
        output mem_rd_data,
        input  io_port_id, io_out_data, io_wr_strobe, io_rd_strobe,
        output io_in_data, io_in_valid
    );

endinterface

// File: rtl/pl_mem_wb_io_in_fsm.sv
// rtl/pl_mem_wb_io_in_fsm.sv - INPUT handshake FSM with timeout and pipeline stall
module pl_io_in_fsm
    import pl_defs::*;
#(
    parameter int IO_TIMEOUT = 16,
    parameter int TMO_WID    = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [3:0]        dest_in,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              stall,
    output logic              rd_strobe,
    output logic              done,
    output logic [DATA_W-1:0] done_data,
    output logic [3:0]        dest
);

    io_state_t          state;
    logic [TMO_WID-1:0] cnt;

    // Data arriving on the final wait cycle still wins over the timeout.
    assign done      = (state == IO_WAIT) && (in_valid || (cnt == TMO_WID'(IO_TIMEOUT - 1)));
    assign done_data = in_valid ? in_data : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            stall     <= 1'b0;
            rd_strobe <= 1'b0;
            dest      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= IO_WAIT;
                        cnt       <= '0;
                        dest      <= dest_in;
                        stall     <= 1'b1;
                        rd_strobe <= 1'b1;
                    end
                end
                IO_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (done) begin
                        state     <= IO_WB;
                        rd_strobe <= 1'b0;
                    end
                end
                IO_WB: begin
                    state <= IDLE;
                    stall <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    stall     <= 1'b0;
                    rd_strobe <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pl_mem_wb.sv
// rtl/pl_mem_wb.sv - memory/writeback stage: memory access, IO ports, regfile write and forwarding
module pl_mem_wb
    import pl_defs::*;
#(
    parameter int NUM_DOMAINS = 1,
    parameter int IO_TIMEOUT  = 16,
    parameter int TMO_WID     = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [0:9]                 EX_reg,
    input  logic [3:0]                 destination_reg_addr,
    input  logic [NUM_DOMAINS*8-1:0]   operation_result,
    input  logic [ADDR_W-1:0]          data_wr_addr,
    input  logic [ADDR_W-1:0]          data_rd_addr,
    input  logic [PORT_W-1:0]          IO_port_ID,
    pl_mem_wb_if.master                bus,
    output logic                       stall_pipeline,
    output logic                       rf_wr_en_int,
    output logic                       rf_wr_en_rns,
    output logic [RF_ADDR_W-1:0]       rf_wr_addr,
    output logic [NUM_DOMAINS*8-1:0]   rf_wr_data,
    output logic                       fwd_valid,
    output logic [3:0]                 fwd_addr,
    output logic [NUM_DOMAINS*8-1:0]   fwd_data
);

    localparam int RES_W = NUM_DOMAINS * DATA_W;

    logic                 kill;
    logic                 ex_go;
    logic                 in_done;
    logic [DATA_W-1:0]    in_data;
    logic [3:0]           in_dest;
    logic                 rd_strobe;
    logic                 stall;

    logic                 wb_int;
    logic                 wb_rns;
    logic                 wb_load;
    logic [RF_ADDR_W-1:0] wb_addr;
    logic [RES_W-1:0]     wb_data;

    logic                 unused_ok;
    assign unused_ok = ^{EX_reg[EXR_SAVE_COUT], EX_reg[EXR_DEST_RNS]};

    assign kill = EX_reg[EXR_INV_EX] | EX_reg[EXR_INV_FETCH] | EX_reg[EXR_INV_DECODE];
    // While stalled, EX holds the instruction after the INPUT; it must act only once IDLE returns.
    assign ex_go = !stall && !kill && !reset;

    assign bus.mem_wr_en   = ex_go & EX_reg[EXR_STORE];
    assign bus.mem_addr    = EX_reg[EXR_STORE] ? data_wr_addr : data_rd_addr;
    assign bus.mem_wr_data = operation_result[DATA_W-1:0];

    pl_io_in_fsm #(
        .IO_TIMEOUT (IO_TIMEOUT),
        .TMO_WID    (TMO_WID)
    ) u_io_in_fsm (
        .clk       (clk),
        .reset     (reset),
        .start     (ex_go & EX_reg[EXR_INP]),
        .dest_in   (destination_reg_addr),
        .in_valid  (bus.io_in_valid),
        .in_data   (bus.io_in_data),
        .stall     (stall),
        .rd_strobe (rd_strobe),
        .done      (in_done),
        .done_data (in_data),
        .dest      (in_dest)
    );

    assign stall_pipeline   = stall;
    assign bus.io_rd_strobe = rd_strobe;

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_int           <= 1'b0;
            wb_rns           <= 1'b0;
            wb_load          <= 1'b0;
            wb_addr          <= '0;
            wb_data          <= '0;
            bus.io_wr_strobe <= 1'b0;
            bus.io_port_id   <= '0;
            bus.io_out_data  <= '0;
        end else begin
            wb_int           <= 1'b0;
            wb_rns           <= 1'b0;
            wb_load          <= 1'b0;
            bus.io_wr_strobe <= 1'b0;
            if (in_done) begin
                wb_int  <= !in_dest[3];
                wb_rns  <= in_dest[3];
                wb_addr <= in_dest[RF_ADDR_W-1:0];
                wb_data <= RES_W'(in_data);
            end else if (ex_go) begin
                if (EX_reg[EXR_LOAD]) begin
                    wb_int  <= !destination_reg_addr[3];
                    wb_rns  <= destination_reg_addr[3];
                    wb_addr <= destination_reg_addr[RF_ADDR_W-1:0];
                    wb_load <= 1'b1;
                end else if (EX_reg[EXR_REG_WR] && !EX_reg[EXR_INP]) begin
                    wb_int  <= !destination_reg_addr[3];
                    wb_rns  <= destination_reg_addr[3];
                    wb_addr <= destination_reg_addr[RF_ADDR_W-1:0];
                    wb_data <= destination_reg_addr[3] ? operation_result
                                                       : RES_W'(operation_result[DATA_W-1:0]);
                end
                if (EX_reg[EXR_OUTP]) begin
                    bus.io_wr_strobe <= 1'b1;
                    bus.io_port_id   <= IO_port_ID;
                    bus.io_out_data  <= operation_result[DATA_W-1:0];
                end else if (EX_reg[EXR_INP]) begin
                    bus.io_port_id   <= IO_port_ID;
                end
            end
        end
    end

    // Load data arrives from the synchronous memory in the write cycle itself.
    assign rf_wr_en_int = wb_int;
    assign rf_wr_en_rns = wb_rns;
    assign rf_wr_addr   = wb_addr;
    assign rf_wr_data   = wb_load ? RES_W'(bus.mem_rd_data) : wb_data;

    assign fwd_valid = wb_int | wb_rns;
    assign fwd_addr  = {wb_rns, wb_addr};
    assign fwd_data  = rf_wr_data;

endmodule

// File: tb/tb_pl_mem_wb.sv
// tb/tb_pl_mem_wb.sv - directed and randomized bench for pl_mem_wb
module tb_pl_mem_wb;

    localparam int ND  = 2;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [0:9]  ex;
    logic [3:0]  dest;
    logic [15:0] res;
    logic [15:0] wa;
    logic [15:0] ra;
    logic [7:0]  port;
    logic        stall_pipeline;
    logic        rf_wr_en_int;
    logic        rf_wr_en_rns;
    logic [2:0]  rf_wr_addr;
    logic [15:0] rf_wr_data;
    logic        fwd_valid;
    logic [3:0]  fwd_addr;
    logic [15:0] fwd_data;

    logic [7:0]  mem_arr [0:255];
    int          passed = 0;
    int          failed = 0;
    int          total  = 0;

    always #5 clk = ~clk;

    pl_mem_wb_if bus();

    pl_mem_wb #(
        .NUM_DOMAINS (ND),
        .IO_TIMEOUT  (TMO),
        .TMO_WID     (5)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .EX_reg               (ex),
        .destination_reg_addr (dest),
        .operation_result     (res),
        .data_wr_addr         (wa),
        .data_rd_addr         (ra),
        .IO_port_ID           (port),
        .bus                  (bus),
        .stall_pipeline       (stall_pipeline),
        .rf_wr_en_int         (rf_wr_en_int),
        .rf_wr_en_rns         (rf_wr_en_rns),
        .rf_wr_addr           (rf_wr_addr),
        .rf_wr_data           (rf_wr_data),
        .fwd_valid            (fwd_valid),
        .fwd_addr             (fwd_addr),
        .fwd_data             (fwd_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; the bench memory answers the address seen before the edge.
    task automatic step();
        logic [15:0] a;
        #1;
        a = bus.mem_addr;
        @(posedge clk);
        #1;
        bus.mem_rd_data = mem_arr[a[7:0]];
        #1;
    endtask

    function automatic logic [0:9] mk(bit st, bit rw, bit ie, bit ld, bit inf, bit ind,
                                      bit rns, bit op, bit ip);
        return {st, rw, 1'b0, ie, ld, inf, ind, rns, op, ip};
    endfunction

    task automatic drive_nop();
        ex   = '0;
        dest = '0;
        res  = '0;
        wa   = '0;
        ra   = '0;
        port = '0;
        bus.io_in_valid = 1'b0;
        bus.io_in_data  = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"},   stall_pipeline, 0);
        chk({tag, "_int"},     rf_wr_en_int, 0);
        chk({tag, "_rns"},     rf_wr_en_rns, 0);
        chk({tag, "_addr"},    rf_wr_addr, 0);
        chk({tag, "_data"},    rf_wr_data, 0);
        chk({tag, "_fwd"},     {fwd_valid, fwd_addr, fwd_data}, 0);
        chk({tag, "_memwr"},   bus.mem_wr_en, 0);
        chk({tag, "_iowr"},    bus.io_wr_strobe, 0);
        chk({tag, "_iord"},    bus.io_rd_strobe, 0);
        chk({tag, "_ioport"},  bus.io_port_id, 0);
        chk({tag, "_ioout"},   bus.io_out_data, 0);
    endtask

    // Issue one non-INPUT instruction in IDLE and check both the same-cycle
    // memory access and the following-cycle writeback against the stage rules.
    task automatic issue(input string tag, input bit st, input bit rw, input bit ie, input bit ld,
                         input bit inf, input bit ind, input bit rns, input bit op,
                         input logic [2:0] a3, input logic [15:0] r,
                         input logic [15:0] w_a, input logic [15:0] r_a, input logic [7:0] p);
        bit          kill;
        bit          wr;
        logic [15:0] maddr;
        logic [15:0] exp_data;
        kill = ie | inf | ind;
        ex   = mk(st, rw, ie, ld, inf, ind, rns, op, 1'b0);
        dest = {rns, a3};
        res  = r;
        wa   = w_a;
        ra   = r_a;
        port = p;
        bus.io_in_valid = 1'($urandom_range(0, 1));
        bus.io_in_data  = 8'($urandom);
        #1;
        maddr = st ? w_a : r_a;
        chk({tag, "_mem_wr_en"}, bus.mem_wr_en, st & !kill);
        chk({tag, "_mem_addr"},  bus.mem_addr, maddr);
        if (st) chk({tag, "_mem_wr_data"}, bus.mem_wr_data, r[7:0]);
        wr = !kill && (ld || rw);
        if (ld)       exp_data = {8'h00, mem_arr[maddr[7:0]]};
        else if (rns) exp_data = r;
        else          exp_data = {8'h00, r[7:0]};
        step();
        chk({tag, "_en_int"},    rf_wr_en_int, wr & !rns);
        chk({tag, "_en_rns"},    rf_wr_en_rns, wr & rns);
        chk({tag, "_fwd_valid"}, fwd_valid, wr);
        if (wr) begin
            chk({tag, "_wr_addr"},  rf_wr_addr, a3);
            chk({tag, "_wr_data"},  rf_wr_data, exp_data);
            chk({tag, "_fwd_addr"}, fwd_addr, {rns, a3});
            chk({tag, "_fwd_data"}, fwd_data, exp_data);
        end
        chk({tag, "_io_wr"}, bus.io_wr_strobe, op & !kill);
        if (op && !kill) begin
            chk({tag, "_io_port"}, bus.io_port_id, p);
            chk({tag, "_io_out"},  bus.io_out_data, r[7:0]);
        end
        chk({tag, "_stall"}, stall_pipeline, 0);
    endtask

    // INPUT whose data becomes valid on wait cycle w (w >= TMO means never).
    // A store+OUTPUT sits in EX during the stall and must fire exactly once afterwards.
    task automatic run_input(input string tag, input logic [7:0] p, input bit rns,
                             input logic [2:0] a3, input int w, input logic [7:0] d);
        int          n;
        logic [7:0]  exp_in;
        logic [15:0] held_res;
        logic [15:0] held_wa;
        n        = (w < TMO) ? w + 1 : TMO;
        exp_in   = (w < TMO) ? d : 8'h00;
        held_res = 16'($urandom);
        held_wa  = 16'($urandom);
        ex   = mk(0, 0, 0, 0, 0, 0, rns, 0, 1);
        dest = {rns, a3};
        port = p;
        bus.io_in_valid = 1'b0;
        #1;
        chk({tag, "_start_memwr"}, bus.mem_wr_en, 0);
        step();
        ex   = mk(1, 0, 0, 0, 0, 0, 0, 1, 0);
        dest = 4'h0;
        res  = held_res;
        wa   = held_wa;
        port = 8'($urandom);
        for (int i = 0; i < n; i++) begin
            bus.io_in_valid = (i == w);
            bus.io_in_data  = (i == w) ? d : 8'($urandom);
            #1;
            chk({tag, "_wait_stall"},  stall_pipeline, 1);
            chk({tag, "_wait_rd"},     bus.io_rd_strobe, 1);
            chk({tag, "_wait_memwr"},  bus.mem_wr_en, 0);
            chk({tag, "_wait_rfwr"},   rf_wr_en_int | rf_wr_en_rns, 0);
            chk({tag, "_wait_port"},   bus.io_port_id, p);
            step();
        end
        bus.io_in_valid = 1'b0;
        #1;
        chk({tag, "_wb_stall"},  stall_pipeline, 1);
        chk({tag, "_wb_rd"},     bus.io_rd_strobe, 0);
        chk({tag, "_wb_memwr"},  bus.mem_wr_en, 0);
        chk({tag, "_wb_en_int"}, rf_wr_en_int, !rns);
        chk({tag, "_wb_en_rns"}, rf_wr_en_rns, rns);
        chk({tag, "_wb_addr"},   rf_wr_addr, a3);
        chk({tag, "_wb_data"},   rf_wr_data, {8'h00, exp_in});
        chk({tag, "_wb_fwd"},    {fwd_valid, fwd_addr}, {1'b1, rns, a3});
        chk({tag, "_wb_iowr"},   bus.io_wr_strobe, 0);
        step();
        chk({tag, "_idle_stall"}, stall_pipeline, 0);
        chk({tag, "_idle_rfwr"},  rf_wr_en_int | rf_wr_en_rns, 0);
        chk({tag, "_held_memwr"}, bus.mem_wr_en, 1);
        chk({tag, "_held_addr"},  bus.mem_addr, held_wa);
        step();
        chk({tag, "_held_iowr"},  bus.io_wr_strobe, 1);
        chk({tag, "_held_ioout"}, bus.io_out_data, held_res[7:0]);
        drive_nop();
        step();
        chk({tag, "_held_once"},  bus.io_wr_strobe, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_arr[i] = 8'($urandom);
        mem_arr[8'h10] = 8'h9C;
        bus.mem_rd_data = '0;
        drive_nop();

        // Reset with a live store on the inputs: nothing may leak out.
        reset = 1'b1;
        ex = mk(1, 1, 0, 0, 0, 0, 0, 1, 0);
        res = 16'h00FF;
        step();
        step();
        chk_all_zero("reset");
        reset = 1'b0;
        drive_nop();
        step();

        issue("add",   0, 1, 0, 0, 0, 0, 0, 0, 3'd3, 16'h002A, 16'h0000, 16'h0000, 8'h00);
        issue("store", 1, 0, 0, 0, 0, 0, 0, 0, 3'd0, 16'h0055, 16'h0102, 16'h0000, 8'h00);
        issue("load",  0, 1, 0, 1, 0, 0, 0, 0, 3'd5, 16'h0000, 16'h0000, 16'h0010, 8'h00);
        issue("load_k",0, 1, 1, 1, 0, 0, 0, 0, 3'd5, 16'h0000, 16'h0000, 16'h0010, 8'h00);
        issue("rns",   0, 1, 0, 0, 0, 0, 1, 0, 3'd2, 16'h1F80, 16'h0000, 16'h0000, 8'h00);
        issue("outp",  0, 0, 0, 0, 0, 0, 0, 1, 3'd0, 16'h00C3, 16'h0000, 16'h0000, 8'h3E);
        drive_nop();
        step();
        chk("outp_one_cycle", bus.io_wr_strobe, 0);

        run_input("in_ack3", 8'h07, 0, 3'd4, 3, 8'hA5);
        run_input("in_tmo",  8'h11, 0, 3'd1, TMO, 8'h77);
        run_input("in_edge", 8'h12, 1, 3'd6, TMO - 1, 8'h5A);
        run_input("in_ack0", 8'h13, 1, 3'd7, 0, 8'hE1);

        // Reset in the middle of an INPUT wait aborts it with no write.
        ex   = mk(0, 0, 0, 0, 0, 0, 0, 0, 1);
        dest = 4'h2;
        port = 8'h44;
        step();
        drive_nop();
        for (int i = 0; i < 5; i++) step();
        chk("rst_mid_stall_before", stall_pipeline, 1);
        reset = 1'b1;
        ex = mk(1, 0, 0, 0, 0, 0, 0, 1, 0);
        step();
        chk_all_zero("rst_mid");
        reset = 1'b0;
        drive_nop();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_mid_no_wr", rf_wr_en_int | rf_wr_en_rns | stall_pipeline, 0);
        end

        for (int it = 0; it < 150; it++) begin
            if ($urandom_range(0, 9) == 0) begin
                run_input("rnd_in", 8'($urandom), 1'($urandom), 3'($urandom),
                          int'($urandom_range(0, TMO + 2)), 8'($urandom));
            end else begin
                issue("rnd", 1'($urandom), 1'($urandom),
                      $urandom_range(0, 5) == 0, 1'($urandom),
                      $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                      1'($urandom), 1'($urandom), 3'($urandom), 16'($urandom),
                      16'($urandom), 16'($urandom), 8'($urandom));
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
